// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Arbitrates the register file's single write port between the
//               in-order pipeline writeback and out-of-order MUL/DIV
//               completions. A starvation counter eventually forces a MUL/DIV
//               grant. A busy-bit scoreboard of pending MUL/DIV destinations
//               stalls decode on RAW/WAW hazards and when too many MUL/DIV
//               operations are outstanding.
// Ports       :
//   clk, reset_n                    clock / async active-low reset
//   iss_*                           decode-stage instruction description
//   stall_reg_rd                    hold decode / regfile read this cycle
//   wb_valid/wb_rd_addr/wb_rd_data  pipeline writeback request
//   wb_ready                        writeback accepted this cycle
//   md_valid/md_rd_addr/md_rd_data  MUL/DIV completion request
//   md_ready                        MUL/DIV completion accepted this cycle
//   wr_rd_en/rd_address/rd_data     registered regfile write port
//   sb_err                          sticky: completion to a non-busy register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int XLEN         = 32,
  parameter int MD_MAX_OUT   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            iss_valid,
  input  logic            iss_rs1_en,
  input  logic [4:0]      iss_rs1_addr,
  input  logic            iss_rs2_en,
  input  logic [4:0]      iss_rs2_addr,
  input  logic            iss_rd_en,
  input  logic [4:0]      iss_rd_addr,
  input  logic            iss_is_md,
  output logic            stall_reg_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic            wb_ready,
  input  logic            md_valid,
  input  logic [4:0]      md_rd_addr,
  input  logic [XLEN-1:0] md_rd_data,
  output logic            md_ready,
  output logic            wr_rd_en,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] rd_data,
  output logic            sb_err
);

  localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [3:0]            c_MD_MAX     = 4'(MD_MAX_OUT);

  logic [31:0]           r_busy;
  logic [3:0]            r_md_cnt;
  logic [c_STARVE_W-1:0] r_starve_cnt;
  logic                  r_sb_err;
  logic                  r_wr_rd_en;
  logic [4:0]            r_rd_address;
  logic [XLEN-1:0]       r_rd_data;

  logic                  w_force;
  logic                  w_grant_md;
  logic                  w_grant_wb;
  logic                  w_stall;
  logic                  w_iss_fire;
  logic                  w_md_inc;
  logic                  w_md_dec;
  logic                  w_sb_viol;
  logic [31:0]           w_set_vec;
  logic [31:0]           w_clr_vec;
  logic [31:0]           w_busy_nxt;
  logic [3:0]            w_md_cnt_nxt;
  logic [c_STARVE_W-1:0] w_starve_nxt;

  // Arbitration: writeback has priority unless MUL/DIV has been refused for
  // STARVE_LIMIT consecutive cycles.
  always_comb begin
    w_force    = (r_starve_cnt == c_STARVE_MAX);
    w_grant_md = md_valid && (w_force || !wb_valid);
    w_grant_wb = wb_valid && !(w_force && md_valid);
  end

  // Hazard detection looks only at registered scoreboard state, so there is
  // no combinational path from the MUL/DIV completion into the stall.
  always_comb begin
    w_stall = iss_valid && ((iss_rs1_en && r_busy[iss_rs1_addr]) ||
                            (iss_rs2_en && r_busy[iss_rs2_addr]) ||
                            (iss_rd_en  && r_busy[iss_rd_addr])  ||
                            (iss_is_md  && (r_md_cnt == c_MD_MAX)));
    w_iss_fire = iss_valid && !w_stall;
  end

  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (w_iss_fire && iss_is_md && iss_rd_en && (iss_rd_addr != 5'd0)) begin
      w_set_vec = 32'h1 << iss_rd_addr;
    end
    if (w_grant_md) begin
      w_clr_vec = 32'h1 << md_rd_addr;
    end
    // Set is applied after clear so a same-index set wins; x0 never busy.
    w_busy_nxt = ((r_busy & ~w_clr_vec) | w_set_vec) & ~32'h1;
    w_sb_viol  = w_grant_md && (md_rd_addr != 5'd0) && !r_busy[md_rd_addr];
  end

  always_comb begin
    w_md_inc     = w_iss_fire && iss_is_md;
    // A completion with nothing outstanding must not wrap the counter.
    w_md_dec     = w_grant_md && (r_md_cnt != 4'd0);
    w_md_cnt_nxt = r_md_cnt;
    if (w_md_inc && !w_md_dec) begin
      w_md_cnt_nxt = r_md_cnt + 4'd1;
    end else if (!w_md_inc && w_md_dec) begin
      w_md_cnt_nxt = r_md_cnt - 4'd1;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!md_valid || w_grant_md) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != c_STARVE_MAX) begin
      w_starve_nxt = r_starve_cnt + c_STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= '0;
      r_md_cnt     <= '0;
      r_starve_cnt <= '0;
      r_sb_err     <= 1'b0;
      r_wr_rd_en   <= 1'b0;
      r_rd_address <= '0;
      r_rd_data    <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_md_cnt     <= w_md_cnt_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_sb_viol) begin
        r_sb_err <= 1'b1;
      end
      // Writes to x0 are consumed (granted) but never reach the regfile.
      if (w_grant_md) begin
        r_wr_rd_en   <= (md_rd_addr != 5'd0);
        r_rd_address <= md_rd_addr;
        r_rd_data    <= md_rd_data;
      end else if (w_grant_wb) begin
        r_wr_rd_en   <= (wb_rd_addr != 5'd0);
        r_rd_address <= wb_rd_addr;
        r_rd_data    <= wb_rd_data;
      end else begin
        r_wr_rd_en   <= 1'b0;
      end
    end
  end

  assign stall_reg_rd = w_stall;
  assign wb_ready     = !(w_force && md_valid);
  assign md_ready     = w_grant_md;
  assign wr_rd_en     = r_wr_rd_en;
  assign rd_address   = r_rd_address;
  assign rd_data      = r_rd_data;
  assign sb_err       = r_sb_err;

endmodule
`default_nettype wire
